mem_rmw_ctrl: RTL
=================

# mem_rmw_ctrl

Byte-enable front end for the core's data RAM. It takes load/store requests from the LSU and drives the write and read ports of the dual-port RAM. That RAM has no byte enables, a 1-cycle read latency, and returns the new value on a read-during-write to the same address. Full-word stores go straight to the RAM. Partial stores become a two-cycle read-modify-write, and loads are pipelined at one per cycle.

## Interface
- DW, 32, data width; a multiple of 8. NB = DW/8.
- AW, 32, address width of both the request and the RAM ports.
- OFF = log2(NB), derived (localparam); byte-offset bits dropped from req_addr.
- clk  in  1  clock.
- rstn  in  1  reset: synchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when valid && ready.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  AW  byte address.
- req_be  in  NB  byte enables; bit i selects bits [8i+7:8i].
- req_wdata  in  DW  store data.
- resp_valid  out  1  one-cycle response pulse.
- resp_rdata  out  DW  load data; 0 for stores.
- ram_wen  out  1  RAM write enable.
- ram_w_addr  out  AW  RAM word write address.
- ram_w_data  out  DW  RAM write data.
- ram_ren  out  1  RAM read enable.
- ram_r_addr  out  AW  RAM word read address.
- ram_r_data  in  DW  RAM read data, valid 1 cycle after ram_ren.

## Operation
- Word address: waddr = {OFF'b0, req_addr[AW-1:OFF]}. Offset bits are ignored and no misalignment check is made.
- FSM states: IDLE and MERGE.
- IDLE: req_ready = 1. MERGE: req_ready = 0.
- Load accepted in IDLE:
  - ram_ren=1, ram_r_addr=waddr, combinationally in the accept cycle.
  - The next cycle: resp_valid=1, resp_rdata=ram_r_data.
  - State stays IDLE, so loads can be issued back to back.
- Full store (req_be all ones) accepted in IDLE:
  - ram_wen=1, ram_w_addr=waddr, ram_w_data=req_wdata in the accept cycle.
  - The next cycle: resp_valid=1, resp_rdata=0. State stays IDLE.
- Partial store (req_be neither 0 nor all ones) accepted in IDLE:
  - Accept cycle: ram_ren=1, ram_r_addr=waddr.
  - Register waddr, req_be and req_wdata, then go to MERGE.
- MERGE:
  - ram_wen=1, ram_w_addr=saved waddr.
  - ram_w_data, byte i = saved_be[i] ? saved_wdata byte i : ram_r_data byte i.
  - Return to IDLE. resp_valid=1 in the following cycle, resp_rdata=0.
- Store with req_be == 0: no RAM access; resp_valid the next cycle with resp_rdata=0.
- Exactly one response per accepted request, in acceptance order.
- Responses have no backpressure; the consumer must take resp_valid when it is asserted.
- Ordering hazards need no extra logic:
  - MERGE blocks new requests.
  - A load issued the cycle after a write sees the updated word.
  - A load in the same cycle as a full store to the same word gets the new data through the RAM bypass.
- ram_w_data and ram_r_addr are don't-care when their enables are 0; the bench checks them only when enabled.

## Timing
- Reset (rstn=0 at a clk edge):
  - State goes to IDLE.
  - resp_valid=0, resp_rdata=0, all saved registers = 0.
  - ram_wen=0, ram_ren=0, req_ready=0 while rstn is low.
- Reset while in MERGE: the merge write is abandoned (no ram_wen) and no response is given.
- Latency: load 1, full store 1, partial store 2 (accept to resp_valid).
- Throughput: loads and full stores 1 per cycle; a partial store occupies 2 cycles.
- req_ready depends only on state, never on req_valid.
- RAM enables are combinational from the request in IDLE and registered state in MERGE; no registered delay is added on the RAM side.

## Test plan
- Load pipeline:
  - Preload word 0x10=0xAABBCCDD and word 0x14=0x11223344.
  - Loads at addr 0x10 and 0x14 on consecutive cycles -> resp_valid on cycles 1 and 2 with those values.
  - req_ready stays 1 throughout.
- Full store then load:
  - Store 0xDEADBEEF, be=4'hF to 0x20, then load 0x20 the next cycle -> store response rdata=0, then load rdata=0xDEADBEEF.
  - Exactly one ram_wen, no ram_ren for the store.
- Partial store:
  - Word 0x30=0x12345678; store wdata=0xAABBCCDD, be=4'b0101.
  - Expect ram_ren in cycle 0, then ram_wen in cycle 1 with data 0x12BB56DD.
  - req_ready=0 in cycle 1; resp_valid in cycle 2.
  - Follow-up load returns 0x12BB56DD.
- Back-to-back partial stores to 0x40 (initial 0):
  - be=0001, wdata=0x000000AA, then be=0010, wdata=0x0000BB00 -> final word 0x0000BBAA.
  - Second accept is delayed one cycle.
- be=0 store -> no ram_wen and no ram_ren; resp_valid after 1 cycle.
- Reset in MERGE:
  - Assert rstn=0 in the MERGE cycle of a partial store to 0x50 (value 0x55555555).
  - Expect no ram_wen, no resp_valid, and the word still 0x55555555.
  - After release: req_ready=1 and outputs are 0.

Source files
------------

// File: rtl/mem_rmw_ctrl.sv
// mem_rmw_ctrl: byte-enable front end for a data RAM that has no byte enables.
//
// The RAM behind this block is dual-port (one write port, one read port) with a
// one-cycle read latency, and returns the new word on a read-during-write to the
// same address. This block turns LSU requests into RAM port activity:
//   - loads             : read issued in the accept cycle, response next cycle
//   - full-word stores  : write issued in the accept cycle, response next cycle
//   - partial stores    : read in the accept cycle, merged write in the next
//                         cycle (MERGE), response the cycle after that
//   - stores with be==0 : no RAM access, response next cycle
//
// Ports:
//   clk, rstn          clock; synchronous active-low reset
//   req_valid/ready    request handshake (ready depends on state only)
//   req_we             1 = store, 0 = load
//   req_addr           byte address (offset bits dropped, no alignment check)
//   req_be, req_wdata  byte enables and store data
//   resp_valid         one-cycle response pulse, no backpressure
//   resp_rdata         load data, 0 for stores
//   ram_wen/w_addr/w_data  RAM write port (word address)
//   ram_ren/r_addr         RAM read port (word address)
//   ram_r_data             RAM read data, valid one cycle after ram_ren
module mem_rmw_ctrl #(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_addr,
  input  logic [DW/8-1:0] req_be,
  input  logic [DW-1:0]   req_wdata,
  output logic            resp_valid,
  output logic [DW-1:0]   resp_rdata,
  output logic            ram_wen,
  output logic [AW-1:0]   ram_w_addr,
  output logic [DW-1:0]   ram_w_data,
  output logic            ram_ren,
  output logic [AW-1:0]   ram_r_addr,
  input  logic [DW-1:0]   ram_r_data
);

  localparam int unsigned NB  = DW / 8;
  localparam int unsigned OFF = (NB > 1) ? $clog2(NB) : 0;

  typedef enum logic [0:0] {
    StIdle,
    StMerge
  } state_e;

  state_e          state_q;
  logic            resp_valid_q;
  // Set for one cycle after a load was accepted; selects RAM data onto resp_rdata.
  logic            load_pend_q;
  logic [AW-1:0]   saved_addr_q;
  logic [NB-1:0]   saved_be_q;
  logic [DW-1:0]   saved_wdata_q;

  logic            in_idle;
  logic            in_merge;
  logic            accept;
  logic            be_full;
  logic            be_zero;
  logic            is_load;
  logic            is_full_store;
  logic            is_part_store;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   merged;

  // ---------------------------------------------------------------------------
  // Request decode
  // ---------------------------------------------------------------------------
  // Shift rather than concatenate so NB == 1 (no offset bits) still elaborates.
  assign waddr = req_addr >> OFF;

  assign in_idle  = (state_q == StIdle);
  assign in_merge = (state_q == StMerge);

  // Ready is forced low while reset is held so nothing is accepted during reset.
  assign req_ready = rstn && in_idle;
  assign accept    = req_valid && req_ready;

  assign be_full       = &req_be;
  assign be_zero       = ~|req_be;
  assign is_load       = accept && !req_we;
  assign is_full_store = accept && req_we && be_full;
  assign is_part_store = accept && req_we && !be_full && !be_zero;

  // ---------------------------------------------------------------------------
  // Byte merge of saved store data over the word read in the accept cycle
  // ---------------------------------------------------------------------------
  always_comb begin
    merged = '0;
    for (int i = 0; i < NB; i++) begin
      merged[8*i +: 8] = saved_be_q[i] ? saved_wdata_q[8*i +: 8] : ram_r_data[8*i +: 8];
    end
  end

  // ---------------------------------------------------------------------------
  // RAM ports: combinational from the request in IDLE, from saved state in MERGE
  // ---------------------------------------------------------------------------
  always_comb begin
    ram_ren    = is_load || is_part_store;
    ram_r_addr = waddr;
    if (in_merge) begin
      // Gated by rstn so a reset during MERGE abandons the write.
      ram_wen    = rstn;
      ram_w_addr = saved_addr_q;
      ram_w_data = merged;
    end else begin
      ram_wen    = is_full_store;
      ram_w_addr = waddr;
      ram_w_data = req_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= StIdle;
      resp_valid_q  <= 1'b0;
      load_pend_q   <= 1'b0;
      saved_addr_q  <= '0;
      saved_be_q    <= '0;
      saved_wdata_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // Every accepted request except a partial store answers next cycle.
          resp_valid_q <= accept && !is_part_store;
          load_pend_q  <= is_load;
          if (is_part_store) begin
            saved_addr_q  <= waddr;
            saved_be_q    <= req_be;
            saved_wdata_q <= req_wdata;
            state_q       <= StMerge;
          end
        end
        StMerge: begin
          resp_valid_q <= 1'b1;
          load_pend_q  <= 1'b0;
          state_q      <= StIdle;
        end
        default: begin
          resp_valid_q <= 1'b0;
          load_pend_q  <= 1'b0;
          state_q      <= StIdle;
        end
      endcase
    end
  end

  assign resp_valid = resp_valid_q;
  // RAM data arrives the cycle after the read, which is the response cycle.
  assign resp_rdata = load_pend_q ? ram_r_data : '0;

endmodule
